// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 7 data bits LSB-first, even parity, one stop bit.
// Centre-samples each bit and hands the character over with a valid/ack handshake.
module uart_rx_oversample #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       data_ack,
    output logic [6:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SampW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    logic rxd_meta_q, rxd_s_q, rxd_prev_q;

    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic [SampW-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic             par_q, par_d;

    logic [6:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       parity_err_q, parity_err_d;
    logic       framing_err_q, framing_err_d;
    logic       overrun_q, overrun_d;

    logic tick;
    logic complete;
    logic half_point;
    logic full_point;

    assign tick       = (div_cnt_q == DivW'(DIV - 1));
    assign half_point = tick && (samp_cnt_q == SampW'(OVERSAMPLE / 2 - 1));
    assign full_point = tick && (samp_cnt_q == SampW'(OVERSAMPLE - 1));

    // Next-state logic for the receive FSM and its counters.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + DivW'(1);
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        complete   = 1'b0;

        if (tick && (state_q != StIdle)) begin
            samp_cnt_d = samp_cnt_q + SampW'(1);
        end

        unique case (state_q)
            StIdle: begin
                // Edge-triggered so a held-low line (break) cannot restart a frame.
                if (rxd_prev_q && !rxd_s_q) begin
                    state_d    = StStart;
                    samp_cnt_d = '0;
                    div_cnt_d  = '0;
                end
            end
            StStart: begin
                if (half_point) begin
                    samp_cnt_d = '0;
                    if (!rxd_s_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (full_point) begin
                    samp_cnt_d = '0;
                    shift_d    = {rxd_s_q, shift_q[6:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd6) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (full_point) begin
                    samp_cnt_d = '0;
                    par_d      = rxd_s_q;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (full_point) begin
                    samp_cnt_d = '0;
                    complete   = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output holding registers and handshake; a completion outranks a same-cycle ack.
    always_comb begin
        data_d        = data_q;
        valid_d       = valid_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;

        if (complete) begin
            data_d        = shift_q;
            parity_err_d  = ^{shift_q, par_q};
            framing_err_d = ~rxd_s_q;
            valid_d       = 1'b1;
            if (valid_q && !data_ack) begin
                overrun_d = 1'b1;
            end
        end else if (data_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q    <= 1'b1;
            rxd_s_q       <= 1'b1;
            rxd_prev_q    <= 1'b1;
            state_q       <= StIdle;
            div_cnt_q     <= '0;
            samp_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rxd_meta_q    <= rxd;
            rxd_s_q       <= rxd_meta_q;
            rxd_prev_q    <= rxd_s_q;
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

16x-oversampling UART receiver that decodes the frame produced by the board's UART transmitter: start bit (0), 7 data bits LSB-first, even parity bit, stop bit (1). It synchronizes the asynchronous serial line, qualifies the start bit at mid-bit, samples every bit at its centre, and presents the 7-bit character with parity, framing and overrun status. A valid/ack handshake lets the display or loopback logic consume each character.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bits per second.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 4.
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `rxd` in 1: asynchronous serial input. The line idles high.
- `data_ack` in 1: consumer has taken the current character.
- `data_out` out 7: received character.
- `data_valid` out 1: a character is held in `data_out`.
- `parity_err` out 1: even-parity mismatch on the held character.
- `framing_err` out 1: stop bit was sampled as 0 on the held character.
- `overrun` out 1: sticky; a character was lost.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer.** `rxd` passes through 2 flops to give `rxd_s`, then 1 more flop to give `rxd_prev`. All three reset to 1.
- **Divider.**
  - `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, integer division.
  - `div_cnt` counts 0..DIV-1. `tick` is asserted when `div_cnt == DIV-1`.
  - `div_cnt` clears to 0 on entry to START.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - Start is detected only on a falling edge: `rxd_prev==1 && rxd_s==0`. A line held low (break) never retriggers.
  - On detection, go to START and clear `samp_cnt` and `div_cnt`.
- **START**
  - On the tick where `samp_cnt == OVERSAMPLE/2-1`, sample `rxd_s`.
  - If it is 0, go to DATA with `samp_cnt=0` and `bit_cnt=0`.
  - If it is 1, this is a glitch: return to IDLE with no output change.
- **DATA**
  - Sample on the tick where `samp_cnt == OVERSAMPLE-1`, then clear `samp_cnt`.
  - Shift into `shift[6:0]` LSB-first.
  - After the 7th bit (`bit_cnt==6`), go to PARITY.
- **PARITY:** sample after `OVERSAMPLE` ticks into `par`, then go to STOP.
- **STOP**
  - Sample after `OVERSAMPLE` ticks.
  - On that same edge, update the outputs and return to IDLE.
- **Output update (completion edge)**
  - `data_out <= shift`.
  - `parity_err <= ^{shift,par}` (1 means odd total, i.e. an error).
  - `framing_err <= ~stop_sample`.
  - `data_valid <= 1`.
- **Handshake**
  - `data_valid` stays high until a cycle with `data_ack=1`. It is 0 from the next edge.
  - `data_out` and the error flags hold until the next completion.
  - Ack while `data_valid=0` is ignored.
- **Completion while `data_valid=1`**
  - Without ack in that cycle: set `overrun <= 1` and overwrite data and flags. `data_valid` stays 1.
  - With ack in the same cycle: completion wins. `data_valid` stays 1 and `overrun` is not set.
- `overrun` clears only on `rst`.
- **Framing error:** data is still delivered with `data_valid=1`.

## Timing
- **Reset:** state IDLE; `data_out=0`; `data_valid`, `parity_err`, `framing_err`, `overrun` and `busy` all 0; counters 0.
- **Reset mid-frame:** the frame is aborted with no `data_valid`, and the receiver returns to IDLE on the next edge.
- **Start detection:** `rxd` falls before edge 0, `rxd_s` is low at edge 2, and START is entered at edge 3. `busy` is high from edge 3.
- **Sample points** are measured from START entry, counted in ticks:
  - start check at `OVERSAMPLE/2`;
  - data bit k at `OVERSAMPLE/2 + (k+1)*OVERSAMPLE`;
  - stop at `OVERSAMPLE/2 + 9*OVERSAMPLE`.
- **Completion** occurs at edge `3 + (OVERSAMPLE/2 + 9*OVERSAMPLE)*DIV` after the `rxd` fall:
  - `data_valid` rises at that edge;
  - `busy` falls at that edge;
  - the receiver is back in IDLE at that edge.
- **Back-to-back frames:** a new start edge is accepted from the cycle after completion. Half a stop bit of margin is enough.
- **Tolerance:** a baud mismatch of ±3% must decode correctly.

## Test plan
Bench setting: `CLK_FREQ=1_600_000`, `BAUD=10_000`, `OVERSAMPLE=16`, so `DIV=10` and one bit is 160 clk.
- Send 0x41 with parity 0 and stop 1 → `data_out=0x41`, `data_valid` at edge 1523 after the fall, both error flags 0; ack → `data_valid` low on the next edge.
- Send 0x55 with parity forced to 1 → `data_out=0x55`, `parity_err=1`, `framing_err=0`.
- Send 0x7F with stop bit 0, then hold `rxd` low for 2000 clk → `framing_err=1`, exactly one `data_valid`, no further frames while the line is low.
- Pulse `rxd` low for 50 clk only → start rejected, `busy` high then low, `data_valid` stays 0.
- Send 0x12 then 0x34 back-to-back with no ack → `data_out=0x34`, `overrun=1`. Repeat with ack in the completion cycle → `overrun` stays 0.
- Assert `rst` during data bit 3 → all outputs 0 on the next edge; the following frame 0x0A decodes correctly.
